// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the single GPR write port among N_REQ writeback sources.
// Define GPR_WB_BYPASS_EN to add the same-cycle read-after-write forwarding compare.
module gpr_wb_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  stall_in,
    input  logic [N_REQ-1:0]      req_valid_in,
    input  logic [N_REQ*AW-1:0]   req_addr_in,
    input  logic [N_REQ*XLEN-1:0] req_data_in,
    output logic [N_REQ-1:0]      req_ready_out,
    output logic                  write_enable_out,
    output logic [AW-1:0]         rd_addr_out,
    output logic [XLEN-1:0]       rd_data_out,
    output logic [15:0]           grant_count_out
`ifdef GPR_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]         rs1_addr_in,
    input  logic [AW-1:0]         rs2_addr_in,
    output logic                  rs1_fwd_out,
    output logic                  rs2_fwd_out,
    output logic [XLEN-1:0]       fwd_data_out
`endif
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_ptr_next;
    logic [PW-1:0]   idx;
    logic            grant_any;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    // Scan from the RR pointer, wrapping; the first valid source wins.
    always_comb begin
        req_ready_out = '0;
        grant_any     = 1'b0;
        sel_addr      = '0;
        sel_data      = '0;
        rr_ptr_next   = rr_ptr;
        idx           = '0;
        if (reset_in && !stall_in) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                idx = PW'((32'(rr_ptr) + k) % N_REQ);
                if (!grant_any && req_valid_in[idx]) begin
                    grant_any          = 1'b1;
                    req_ready_out[idx] = 1'b1;
                    sel_addr           = req_addr_in[idx*AW +: AW];
                    sel_data           = req_data_in[idx*XLEN +: XLEN];
                    rr_ptr_next        = PW'((32'(idx) + 1) % N_REQ);
                end
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            write_enable_out <= 1'b0;
            rd_addr_out      <= '0;
            rd_data_out      <= '0;
            grant_count_out  <= '0;
            rr_ptr           <= '0;
        end else if (!stall_in) begin
            if (grant_any) begin
                // x0 writes are accepted and counted but never enable the GPR write.
                write_enable_out <= (sel_addr != '0);
                rd_addr_out      <= sel_addr;
                rd_data_out      <= sel_data;
                rr_ptr           <= rr_ptr_next;
                grant_count_out  <= grant_count_out + 16'd1;
            end else begin
                write_enable_out <= 1'b0;
            end
        end
    end

`ifdef GPR_WB_BYPASS_EN
    assign rs1_fwd_out  = write_enable_out & (rs1_addr_in == rd_addr_out);
    assign rs2_fwd_out  = write_enable_out & (rs2_addr_in == rd_addr_out);
    assign fwd_data_out = rd_data_out;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: per-cycle reference model plus directed literal checks.
module tb_gpr_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int A  = 5;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic [N-1:0]    valid = '0;
    logic [N*A-1:0]  addr  = '0;
    logic [N*XL-1:0] data  = '0;
    logic [N-1:0]    ready;
    logic            we;
    logic [A-1:0]    rd;
    logic [XL-1:0]   wdata;
    logic [15:0]     count;
`ifdef GPR_WB_BYPASS_EN
    logic [A-1:0]    rs1 = '0;
    logic [A-1:0]    rs2 = '0;
    logic            rs1_fwd;
    logic            rs2_fwd;
    logic [XL-1:0]   fwd_data;
`endif

    gpr_wb_arbiter #(.N_REQ(N), .XLEN(XL), .AW(A)) dut (
        .clock_in         (clk),
        .reset_in         (rst_n),
        .stall_in         (stall),
        .req_valid_in     (valid),
        .req_addr_in      (addr),
        .req_data_in      (data),
        .req_ready_out    (ready),
        .write_enable_out (we),
        .rd_addr_out      (rd),
        .rd_data_out      (wdata),
        .grant_count_out  (count)
`ifdef GPR_WB_BYPASS_EN
        ,
        .rs1_addr_in      (rs1),
        .rs2_addr_in      (rs2),
        .rs1_fwd_out      (rs1_fwd),
        .rs2_fwd_out      (rs2_fwd),
        .fwd_data_out     (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: architectural state of the write port and arbitration pointer.
    int          m_ptr   = 0;
    logic        m_we    = 1'b0;
    logic [A-1:0]  m_addr  = '0;
    logic [XL-1:0] m_data  = '0;
    logic [15:0]   m_count = '0;

    function automatic int winner();
        if (!rst_n || stall) return -1;
        for (int k = 0; k < N; k++) begin
            if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int g;
        if (!rst_n) begin
            m_ptr   <= 0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_count <= '0;
        end else if (!stall) begin
            g = winner();
            if (g >= 0) begin
                m_addr  <= addr[g*A +: A];
                m_data  <= data[g*XL +: XL];
                m_we    <= (addr[g*A +: A] != '0);
                m_ptr   <= (g + 1) % N;
                m_count <= m_count + 16'd1;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int g;
        logic [N-1:0] exp_ready;
        g = winner();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("mdl_ready", 64'(ready), 64'(exp_ready));
        check("mdl_we",    64'(we),    64'(m_we));
        check("mdl_rd",    64'(rd),    64'(m_addr));
        check("mdl_data",  64'(wdata), 64'(m_data));
        check("mdl_count", 64'(count), 64'(m_count));
`ifdef GPR_WB_BYPASS_EN
        check("mdl_rs1_fwd", 64'(rs1_fwd), 64'(m_we & (rs1 == m_addr)));
        check("mdl_rs2_fwd", 64'(rs2_fwd), 64'(m_we & (rs2 == m_addr)));
        check("mdl_fwd_data", 64'(fwd_data), 64'(m_data));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_r;
        // Reset: ready must stay low even with requests pending.
        repeat (3) @(posedge clk);
        #1;
        valid = 3'b111;
        #1;
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_we",    64'(we),    64'h0);
        check("rst_count", 64'(count), 64'h0);
        valid = '0;

        // Single write from source 0.
        rst_n = 1'b1;
        valid = 3'b001;
        addr[0 +: A]  = 5'd5;
        data[0 +: XL] = 32'hDEADBEEF;
        #1;
        check("t1_ready", 64'(ready), 64'h1);
        tick();
        valid = '0;
        #1;
        check("t1_we",    64'(we),    64'h1);
        check("t1_rd",    64'(rd),    64'h5);
        check("t1_data",  64'(wdata), 64'hDEADBEEF);
        check("t1_count", 64'(count), 64'h1);
        check("t1_idle",  64'(ready), 64'h0);

        // All sources valid: strict rotation 0,1,2,0,1,2.
        do_reset();
        for (int i = 0; i < N; i++) begin
            addr[i*A +: A]   = A'(i + 1);
            data[i*XL +: XL] = 32'h100 + 32'(i);
        end
        valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_r = 3'(1 << (i % 3));
            check("t2_ready", 64'(ready), 64'(exp_r));
            if (i > 0) begin
                check("t2_we", 64'(we), 64'h1);
                check("t2_rd", 64'(rd), 64'((i - 1) % 3 + 1));
            end
            tick();
        end
        valid = '0;
        #1;
        check("t2_count", 64'(count), 64'h6);
        check("t2_rd_last", 64'(rd), 64'h3);

        // x0 write: consumed and counted, never enables the write port.
        valid = 3'b010;
        addr[1*A +: A]   = 5'd0;
        data[1*XL +: XL] = 32'h1234;
        #1;
        check("t3_ready", 64'(ready), 64'h2);
        tick();
        valid = '0;
        #1;
        check("t3_we",    64'(we),    64'h0);
        check("t3_data",  64'(wdata), 64'h1234);
        check("t3_count", 64'(count), 64'h7);

        // Grant then three stalled cycles: outputs and pointer hold.
        valid = 3'b100;
        addr[2*A +: A]   = 5'd9;
        data[2*XL +: XL] = 32'hAB;
        #1;
        check("t4_ready", 64'(ready), 64'h4);
        tick();
        stall = 1'b1;
        valid = 3'b111;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t4_stall_ready", 64'(ready), 64'h0);
            check("t4_stall_we",    64'(we),    64'h1);
            check("t4_stall_rd",    64'(rd),    64'h9);
            check("t4_stall_data",  64'(wdata), 64'hAB);
            tick();
        end
        stall = 1'b0;
        #1;
        check("t4_resume_ready", 64'(ready), 64'h1);
        check("t4_count", 64'(count), 64'h8);

        // Asynchronous reset mid-burst.
        tick();
        check("t5_we_before", 64'(we), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_we",    64'(we),    64'h0);
        check("t5_async_rd",    64'(rd),    64'h0);
        check("t5_async_data",  64'(wdata), 64'h0);
        check("t5_async_count", 64'(count), 64'h0);
        check("t5_async_ready", 64'(ready), 64'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_first_ready", 64'(ready), 64'h1);
        tick();
        check("t5_first_rd", 64'(rd), 64'h1);

`ifdef GPR_WB_BYPASS_EN
        do_reset();
        valid = 3'b001;
        addr[0 +: A]  = 5'd7;
        data[0 +: XL] = 32'h55;
        tick();
        valid = '0;
        rs1 = 5'd7;
        rs2 = 5'd8;
        #1;
        check("t6_rs1_fwd",   64'(rs1_fwd),  64'h1);
        check("t6_rs2_fwd",   64'(rs2_fwd),  64'h0);
        check("t6_fwd_data",  64'(fwd_data), 64'h55);
`endif

        // 65536 grants wrap the counter back to zero.
        do_reset();
        valid = 3'b111;
        repeat (65535) tick();
        check("t6_count_max", 64'(count), 64'hFFFF);
        tick();
        valid = '0;
        check("t6_count_wrap", 64'(count), 64'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
